lift_call_scheduler: RTL and testbench

- Collects hall calls from per-floor buttons and dispatches each call to one of two lifts, nearest lift first.
- Sequences each lift through move, door-open and idle phases.
- Publishes each lift's floor and up/down/door status to the display and indicator logic downstream.
- Top-level dispatcher feeding the lift selection and indicator path.

---
 rtl/lift_call_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_lift_call_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler: latches per-floor hall calls, hands the lowest pending
// floor to the nearest idle lift (lift 1 wins ties), and runs each lift
// through IDLE -> MOVE -> DOOR -> IDLE. All outputs are registered.
// Optional build macro LIFT_CALL_SCHED_EMERG_EN adds an emerg_stop input
// that freezes travel and door timing and blocks dispatch while high.
module lift_call_scheduler #(
    parameter int NFLOORS     = 10,
    parameter int FLOOR_TICKS = 8,
    parameter int DOOR_TICKS  = 4,
    parameter int L1_HOME     = 0,
    parameter int L2_HOME     = 9
) (
    input  logic               clock,
    input  logic               reset,
`ifdef LIFT_CALL_SCHED_EMERG_EN
    input  logic               emerg_stop,
`endif
    input  logic [NFLOORS-1:0] call_req,
    output logic [NFLOORS-1:0] call_pending,
    output logic               grant_valid,
    output logic               grant_lift,
    output logic [3:0]         grant_floor,
    output logic [3:0]         l1_floor,
    output logic [3:0]         l2_floor,
    output logic               l1_up,
    output logic               l1_down,
    output logic               l1_door,
    output logic               l2_up,
    output logic               l2_down,
    output logic               l2_door
);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} lift_state_t;

    // Travel and door counters; both tick limits must fit in 8 bits.
    localparam int CW = 8;

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Registered state, index 0 = lift 1, index 1 = lift 2.
    lift_state_t         r_state  [2];
    logic [3:0]          r_floor  [2];
    logic [3:0]          r_target [2];
    logic                r_dir    [2];   // 1 = travelling up
    logic [CW-1:0]       r_tcnt   [2];
    logic [CW-1:0]       r_dcnt   [2];
    logic                r_up     [2];
    logic                r_down   [2];
    logic                r_door   [2];
    logic [NFLOORS-1:0]  r_pending;
    logic [NFLOORS-1:0]  r_assigned;
    logic                r_grant_valid;
    logic                r_grant_lift;
    logic [3:0]          r_grant_floor;

    // Next-state values.
    lift_state_t         w_state_nxt  [2];
    logic [3:0]          w_floor_nxt  [2];
    logic [3:0]          w_target_nxt [2];
    logic                w_dir_nxt    [2];
    logic [CW-1:0]       w_tcnt_nxt   [2];
    logic [CW-1:0]       w_dcnt_nxt   [2];
    logic                w_up_nxt     [2];
    logic                w_down_nxt   [2];
    logic                w_door_nxt   [2];
    logic                w_door_done  [2];

    logic                w_emerg;
    logic [3:0]          w_pick_floor;
    logic                w_idle0;
    logic                w_idle1;
    logic                w_grant;
    logic                w_grant_lift;
    logic [NFLOORS-1:0]  w_clear_mask;
    logic [NFLOORS-1:0]  w_done_mask;

`ifdef LIFT_CALL_SCHED_EMERG_EN
    assign w_emerg = emerg_stop;
`else
    assign w_emerg = 1'b0;
`endif

    assign w_idle0 = (r_state[0] == S_IDLE);
    assign w_idle1 = (r_state[1] == S_IDLE);

    // Dispatch: lowest pending floor goes to the nearest idle lift.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_pick_floor = '0;
        for (int n = NFLOORS - 1; n >= 0; n--) begin
            if (r_pending[n]) w_pick_floor = 4'(n);
        end
        w_grant = (|r_pending) && (w_idle0 || w_idle1) && !w_emerg;
        if (w_idle0 && w_idle1)
            w_grant_lift = abs_diff(w_pick_floor, r_floor[1]) < abs_diff(w_pick_floor, r_floor[0]);
        else
            w_grant_lift = w_idle1;
        for (int n = 0; n < NFLOORS; n++) begin
            w_clear_mask[n] = w_grant && (w_pick_floor == 4'(n));
            w_done_mask[n]  = (w_door_done[0] && (r_floor[0] == 4'(n))) ||
                              (w_door_done[1] && (r_floor[1] == 4'(n)));
        end
    end

    // Per-lift next-state and next-indicator logic.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_state_nxt[i]  = r_state[i];
            w_floor_nxt[i]  = r_floor[i];
            w_target_nxt[i] = r_target[i];
            w_dir_nxt[i]    = r_dir[i];
            w_tcnt_nxt[i]   = r_tcnt[i];
            w_dcnt_nxt[i]   = r_dcnt[i];
            w_up_nxt[i]     = 1'b0;
            w_down_nxt[i]   = 1'b0;
            w_door_nxt[i]   = 1'b0;
            w_door_done[i]  = 1'b0;
            case (r_state[i])
                S_IDLE: begin
                    if (w_grant && (w_grant_lift == 1'(i))) begin
                        w_target_nxt[i] = w_pick_floor;
                        if (w_pick_floor == r_floor[i]) begin
                            w_state_nxt[i] = S_DOOR;
                            w_dcnt_nxt[i]  = '0;
                            w_door_nxt[i]  = 1'b1;
                        end else begin
                            w_state_nxt[i] = S_MOVE;
                            w_tcnt_nxt[i]  = '0;
                            w_dir_nxt[i]   = (w_pick_floor > r_floor[i]);
                            w_up_nxt[i]    = (w_pick_floor > r_floor[i]);
                            w_down_nxt[i]  = !(w_pick_floor > r_floor[i]);
                        end
                    end
                end
                S_MOVE: begin
                    // Emergency stop holds floor and counter with both arrows dark.
                    if (!w_emerg) begin
                        if (r_tcnt[i] == CW'(FLOOR_TICKS - 1)) begin
                            w_tcnt_nxt[i]  = '0;
                            w_floor_nxt[i] = r_dir[i] ? (r_floor[i] + 4'd1) : (r_floor[i] - 4'd1);
                            if (w_floor_nxt[i] == r_target[i]) begin
                                w_state_nxt[i] = S_DOOR;
                                w_dcnt_nxt[i]  = '0;
                                w_door_nxt[i]  = 1'b1;
                            end else begin
                                w_up_nxt[i]   = r_dir[i];
                                w_down_nxt[i] = !r_dir[i];
                            end
                        end else begin
                            w_tcnt_nxt[i] = r_tcnt[i] + 1'b1;
                            w_up_nxt[i]   = r_dir[i];
                            w_down_nxt[i] = !r_dir[i];
                        end
                    end
                end
                S_DOOR: begin
                    w_door_nxt[i] = 1'b1;
                    if (!w_emerg) begin
                        if (r_dcnt[i] == CW'(DOOR_TICKS - 1)) begin
                            w_state_nxt[i] = S_IDLE;
                            w_door_nxt[i]  = 1'b0;
                            w_door_done[i] = 1'b1;
                        end else begin
                            w_dcnt_nxt[i] = r_dcnt[i] + 1'b1;
                        end
                    end
                end
                default: w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    // State, call latch and grant registers.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_pending     <= '0;
            r_assigned    <= '0;
            r_grant_valid <= 1'b0;
            r_grant_lift  <= 1'b0;
            r_grant_floor <= '0;
            r_floor[0]    <= 4'(L1_HOME);
            r_floor[1]    <= 4'(L2_HOME);
            for (int i = 0; i < 2; i++) begin
                r_state[i]  <= S_IDLE;
                r_target[i] <= '0;
                r_dir[i]    <= 1'b0;
                r_tcnt[i]   <= '0;
                r_dcnt[i]   <= '0;
                r_up[i]     <= 1'b0;
                r_down[i]   <= 1'b0;
                r_door[i]   <= 1'b0;
            end
        end else begin
            r_pending     <= (r_pending & ~w_clear_mask) | (call_req & ~r_assigned & ~r_pending);
            r_assigned    <= (r_assigned | w_clear_mask) & ~w_done_mask;
            r_grant_valid <= w_grant;
            if (w_grant) begin
                r_grant_lift  <= w_grant_lift;
                r_grant_floor <= w_pick_floor;
            end
            for (int i = 0; i < 2; i++) begin
                r_state[i]  <= w_state_nxt[i];
                r_floor[i]  <= w_floor_nxt[i];
                r_target[i] <= w_target_nxt[i];
                r_dir[i]    <= w_dir_nxt[i];
                r_tcnt[i]   <= w_tcnt_nxt[i];
                r_dcnt[i]   <= w_dcnt_nxt[i];
                r_up[i]     <= w_up_nxt[i];
                r_down[i]   <= w_down_nxt[i];
                r_door[i]   <= w_door_nxt[i];
            end
        end
    end

    assign call_pending = r_pending;
    assign grant_valid  = r_grant_valid;
    assign grant_lift   = r_grant_lift;
    assign grant_floor  = r_grant_floor;
    assign l1_floor     = r_floor[0];
    assign l2_floor     = r_floor[1];
    assign l1_up        = r_up[0];
    assign l1_down      = r_down[0];
    assign l1_door      = r_door[0];
    assign l2_up        = r_up[1];
    assign l2_down      = r_down[1];
    assign l2_door      = r_door[1];

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Bench for lift_call_scheduler: table of single-call trips from reset plus
// hand-written sequences (simultaneous calls, both lifts busy, reset mid-move,
// tie with a second instance using L2_HOME=8, and emergency stop when built
// with LIFT_CALL_SCHED_EMERG_EN). Grants are scoreboarded.
module tb_lift_call_scheduler;

    localparam int NF = 10;
    localparam int FT = 8;
    localparam int DT = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] call_req = '0;
    logic [NF-1:0] call_pending;
    logic          grant_valid, grant_lift;
    logic [3:0]    grant_floor, l1_floor, l2_floor;
    logic          l1_up, l1_down, l1_door, l2_up, l2_down, l2_door;

    // Second instance for the equal-distance case.
    logic          reset8 = 1'b1;
    logic [NF-1:0] call_req8 = '0;
    logic [NF-1:0] call_pending8;
    logic          grant_valid8, grant_lift8;
    logic [3:0]    grant_floor8, l1_floor8, l2_floor8;
    logic          l1_up8, l1_down8, l1_door8, l2_up8, l2_down8, l2_door8;

`ifdef LIFT_CALL_SCHED_EMERG_EN
    logic          emerg_stop = 1'b0;
    logic          emerg_stop8 = 1'b0;
`endif

    always #5 clock = ~clock;

    lift_call_scheduler #(.NFLOORS(NF), .FLOOR_TICKS(FT), .DOOR_TICKS(DT),
                          .L1_HOME(0), .L2_HOME(9)) dut (
        .clock(clock), .reset(reset),
`ifdef LIFT_CALL_SCHED_EMERG_EN
        .emerg_stop(emerg_stop),
`endif
        .call_req(call_req), .call_pending(call_pending),
        .grant_valid(grant_valid), .grant_lift(grant_lift), .grant_floor(grant_floor),
        .l1_floor(l1_floor), .l2_floor(l2_floor),
        .l1_up(l1_up), .l1_down(l1_down), .l1_door(l1_door),
        .l2_up(l2_up), .l2_down(l2_down), .l2_door(l2_door));

    lift_call_scheduler #(.NFLOORS(NF), .FLOOR_TICKS(FT), .DOOR_TICKS(DT),
                          .L1_HOME(0), .L2_HOME(8)) dut8 (
        .clock(clock), .reset(reset8),
`ifdef LIFT_CALL_SCHED_EMERG_EN
        .emerg_stop(emerg_stop8),
`endif
        .call_req(call_req8), .call_pending(call_pending8),
        .grant_valid(grant_valid8), .grant_lift(grant_lift8), .grant_floor(grant_floor8),
        .l1_floor(l1_floor8), .l2_floor(l2_floor8),
        .l1_up(l1_up8), .l1_down(l1_down8), .l1_door(l1_door8),
        .l2_up(l2_up8), .l2_down(l2_down8), .l2_door(l2_door8));

    typedef struct {
        logic       lift;
        logic [3:0] floor;
    } grant_t;

    // One trip from reset: call a floor, expect lift, direction (0 none,
    // 1 up, 2 down), cycles with an arrow lit and cycles with the door open.
    typedef struct {
        int   floor;
        logic lift;
        int   dir;
        int   move;
        int   door;
    } vec_t;

    grant_t sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] lf_floor(input logic l);
        return l ? l2_floor : l1_floor;
    endfunction
    function automatic logic lf_up(input logic l);
        return l ? l2_up : l1_up;
    endfunction
    function automatic logic lf_down(input logic l);
        return l ? l2_down : l1_down;
    endfunction
    function automatic logic lf_door(input logic l);
        return l ? l2_door : l1_door;
    endfunction

    // Scoreboard and per-cycle exclusivity of the indicators.
    always @(negedge clock) begin
        if (!reset) begin
            check("excl_l1", 32'(int'(l1_up) + int'(l1_down) + int'(l1_door) <= 1), 1);
            check("excl_l2", 32'(int'(l2_up) + int'(l2_down) + int'(l2_door) <= 1), 1);
            if (grant_valid) begin
                check("grant_expected", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    grant_t g;
                    g = sb_q.pop_front();
                    check("grant_lift", grant_lift, g.lift);
                    check("grant_floor", grant_floor, g.floor);
                end
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        call_req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pending"}, call_pending, '0);
        check({tag, "_gvalid"}, grant_valid, 0);
        check({tag, "_l1_floor"}, l1_floor, 0);
        check({tag, "_l2_floor"}, l2_floor, 9);
        check({tag, "_ind"}, {l1_up, l1_down, l1_door, l2_up, l2_down, l2_door}, 0);
    endtask

    task automatic wait_all_idle(input string tag);
        int k;
        k = 0;
        while ({l1_up, l1_down, l1_door, l2_up, l2_down, l2_door} != 0 && k < 200) begin
            k++;
            @(negedge clock);
        end
        check({tag, "_settle"}, 32'(k < 200), 1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [NF-1:0] onehot;
        int  start, k, expf;
        bit  track_ok, saw_up, saw_down;
        onehot = '0;
        onehot[v.floor] = 1'b1;
        do_reset();
        check_reset_state("vec_rst");
        sb_q.push_back('{v.lift, 4'(v.floor)});
        call_req = onehot;
        @(negedge clock);
        call_req = '0;
        check("vec_pend_latch", call_pending, onehot);
        check("vec_no_early_grant", grant_valid, 0);
        @(negedge clock);
        check("vec_grant_latency", grant_valid, 1);
        start = v.lift ? 9 : 0;
        k = 0; track_ok = 1; saw_up = 0; saw_down = 0;
        while ((lf_up(v.lift) || lf_down(v.lift)) && k < 500) begin
            saw_up   |= lf_up(v.lift);
            saw_down |= lf_down(v.lift);
            expf = (v.dir == 1) ? start + k / FT : start - k / FT;
            if (int'(lf_floor(v.lift)) != expf) track_ok = 0;
            k++;
            @(negedge clock);
        end
        check("vec_move_cycles", k, v.move);
        check("vec_floor_track", track_ok, 1);
        check("vec_dir", {saw_down, saw_up}, v.dir);
        k = 0;
        while (lf_door(v.lift) && k < 500) begin
            k++;
            @(negedge clock);
        end
        check("vec_door_cycles", k, v.door);
        check("vec_final_floor", lf_floor(v.lift), v.floor);
        check("vec_pend_clear", call_pending, '0);
        check("vec_idle_ind", {lf_up(v.lift), lf_down(v.lift), lf_door(v.lift)}, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   k;
        bit   held_ok, seen_door;

        vecs[0] = '{3, 1'b0, 1, 3 * FT, DT};   // up three floors
        vecs[1] = '{0, 1'b0, 0, 0,      DT};   // lift 1 already there
        vecs[2] = '{9, 1'b1, 0, 0,      DT};   // lift 2 already there
        vecs[3] = '{7, 1'b1, 2, 2 * FT, DT};   // d 7 vs 2
        vecs[4] = '{4, 1'b0, 1, 4 * FT, DT};   // d 4 vs 5
        vecs[5] = '{5, 1'b1, 2, 4 * FT, DT};   // d 5 vs 4
        vecs[6] = '{8, 1'b1, 2, 1 * FT, DT};   // d 8 vs 1

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Floors 2 and 7 together: 2 -> lift 1, next edge 7 -> lift 2.
        do_reset();
        sb_q.push_back('{1'b0, 4'd2});
        sb_q.push_back('{1'b1, 4'd7});
        call_req = NF'(1 << 2) | NF'(1 << 7);
        @(negedge clock);
        call_req = '0;
        check("pair_pending", call_pending, NF'(1 << 2) | NF'(1 << 7));
        @(negedge clock);
        check("pair_grant1", grant_valid, 1);
        check("pair_pending_after1", call_pending, NF'(1 << 7));
        @(negedge clock);
        check("pair_grant2", grant_valid, 1);
        check("pair_pending_after2", call_pending, '0);
        k = 0;
        while (l2_down && k < 500) begin
            k++;
            @(negedge clock);
        end
        check("pair_l2_down_cycles", k, 2 * FT);
        wait_all_idle("pair");
        check("pair_l1_floor", l1_floor, 2);
        check("pair_l2_floor", l2_floor, 7);

        // Both lifts busy: floor 5 waits, then goes to lift 1 once it idles.
        do_reset();
        sb_q.push_back('{1'b1, 4'd6});
        call_req = NF'(1 << 6);
        @(negedge clock);
        sb_q.push_back('{1'b0, 4'd1});
        call_req = NF'(1 << 1);
        @(negedge clock);
        call_req = '0;
        @(negedge clock);
        check("busy_both_moving", {l1_up, l2_down}, 2'b11);
        sb_q.push_back('{1'b0, 4'd5});
        call_req[5] = 1'b1;
        @(negedge clock);
        check("busy_latch", call_pending[5], 1);
        k = 0; held_ok = 1; seen_door = 0;
        while (!(seen_door && !l1_door) && k < 200) begin
            call_req[5] = ~call_req[5];
            if (!call_pending[5] || grant_valid) held_ok = 0;
            if (l1_door) seen_door = 1;
            k++;
            @(negedge clock);
        end
        check("busy_held", held_ok, 1);
        check("busy_pend_at_idle", call_pending[5], 1);
        check("busy_no_grant_at_idle", grant_valid, 0);
        call_req[5] = ~call_req[5];
        @(negedge clock);
        check("busy_grant_next_edge", grant_valid, 1);
        k = 0;
        while (!(l1_door && l1_floor == 4'd5) && k < 200) begin
            call_req[5] = ~call_req[5];
            k++;
            @(negedge clock);
        end
        call_req = '0;
        check("busy_arrive5", 32'(k < 200), 1);
        wait_all_idle("busy");
        check("busy_pend_clear", call_pending, '0);
        check("busy_l2_floor", l2_floor, 6);

        // Reset while lift 1 is travelling past floor 2.
        do_reset();
        sb_q.push_back('{1'b0, 4'd3});
        call_req = NF'(1 << 3);
        @(negedge clock);
        call_req = '0;
        k = 0;
        while (l1_floor != 4'd2 && k < 100) begin
            k++;
            @(negedge clock);
        end
        check("midrst_reach2", l1_floor, 2);
        check("midrst_moving", l1_up, 1);
        reset    = 1'b1;
        call_req = NF'(1 << 4);
        @(negedge clock);
        check_reset_state("midrst");
        reset    = 1'b0;
        call_req = '0;
        @(negedge clock);
        check("midrst_stays_idle", {l1_up, l1_down, l1_door, l2_up, l2_down, l2_door}, 0);
        check("midrst_l1_floor_hold", l1_floor, 0);

        // Equal distance with L2_HOME=8: floor 4 goes to lift 1.
        reset8 = 1'b1;
        repeat (2) @(negedge clock);
        reset8    = 1'b0;
        call_req8 = NF'(1 << 4);
        @(negedge clock);
        call_req8 = '0;
        k = 0;
        while (!grant_valid8 && k < 10) begin
            k++;
            @(negedge clock);
        end
        check("tie_grant_seen", grant_valid8, 1);
        check("tie_lift", grant_lift8, 0);
        check("tie_floor", grant_floor8, 4);
        check("tie_l1_up", l1_up8, 1);

`ifdef LIFT_CALL_SCHED_EMERG_EN
        // Emergency stop for 20 cycles mid-trip delays arrival by 20 cycles.
        begin
            logic [3:0] frozen_floor;
            bit         frozen_ok;
            do_reset();
            sb_q.push_back('{1'b0, 4'd3});
            call_req = NF'(1 << 3);
            @(negedge clock);
            call_req = '0;
            @(negedge clock);
            check("emerg_grant", grant_valid, 1);
            k = 0;
            repeat (10) begin
                k++;
                @(negedge clock);
            end
            emerg_stop   = 1'b1;
            frozen_floor = l1_floor;
            frozen_ok    = 1;
            call_req     = NF'(1 << 8);
            for (int i = 0; i < 20; i++) begin
                k++;
                @(negedge clock);
                call_req = '0;
                if (l1_up || l1_floor != frozen_floor || grant_valid) frozen_ok = 0;
            end
            check("emerg_frozen", frozen_ok, 1);
            check("emerg_latched", call_pending[8], 1);
            emerg_stop = 1'b0;
            sb_q.push_back('{1'b1, 4'd8});
            while (!l1_door && k < 200) begin
                k++;
                @(negedge clock);
            end
            check("emerg_arrival", k, 3 * FT + 20);
            check("emerg_floor", l1_floor, 3);
            wait_all_idle("emerg");
        end
`endif

        repeat (3) @(negedge clock);
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
